alu_seq_unit: RTL and testbench

Parametrised successor of the team's loadable-register ALU. Operands and opcode are loaded from a shared data bus. Execution starts on an explicit start strobe and reports completion with a one-cycle done pulse. The opcode space grows to 8 operations, including carry-chained add, multi-cycle barrel-free shifts and a sequential shift-add multiplier. Sits behind the same register-load control path, with a busy/done handshake for the controlling FSM.

---
 rtl/alu_seq_unit.sv | 204 ++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
// Sequential ALU with operand/opcode registers loaded from a shared bus and a start/busy/done
// handshake. Shifts take one RUN cycle per bit, and MUL is an N-step shift-add.
module alu_seq_unit #(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_A,
  input  logic         load_B,
  input  logic         load_Op,
  input  logic [N-1:0] data_in,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic [4:0]   flags
);

  localparam int unsigned KW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef enum logic [2:0] {
    OpNor  = 3'd0,
    OpNand = 3'd1,
    OpAdd  = 3'd2,
    OpSub  = 3'd3,
    OpAddc = 3'd4,
    OpShl  = 3'd5,
    OpShr  = 3'd6,
    OpMul  = 3'd7
  } op_e;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]     op_q, op_d;
  // Working copies taken at start so that new loads only affect the next operation.
  logic [N-1:0]   wa_q, wa_d, wb_q, wb_d;
  logic [2:0]     wop_q, wop_d;
  logic           cin_q, cin_d;
  logic [N-1:0]   acc_q, acc_d, hi_q, hi_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sc_q, sc_d;
  logic [N-1:0]   result_q, result_d;
  logic [4:0]     flags_q, flags_d;
  logic           done_q, done_d;

  logic [N:0]     add_sum, sub_diff, mul_sum;
  logic [N-1:0]   res_c;
  logic           c_c, v_c;

  // Final result and flags, evaluated from the working registers while in DONE.
  always_comb begin
    add_sum  = {1'b0, wa_q} + {1'b0, wb_q} + {{N{1'b0}}, (wop_q == OpAddc) & cin_q};
    sub_diff = {1'b0, wa_q} - {1'b0, wb_q};
    res_c    = '0;
    c_c      = 1'b0;
    v_c      = 1'b0;
    unique case (op_e'(wop_q))
      OpNor:  res_c = ~(wa_q | wb_q);
      OpNand: res_c = ~(wa_q & wb_q);
      OpAdd, OpAddc: begin
        res_c = add_sum[N-1:0];
        c_c   = add_sum[N];
        v_c   = (wa_q[N-1] == wb_q[N-1]) && (add_sum[N-1] != wa_q[N-1]);
      end
      OpSub: begin
        res_c = sub_diff[N-1:0];
        c_c   = sub_diff[N];
        v_c   = (wa_q[N-1] != wb_q[N-1]) && (sub_diff[N-1] != wa_q[N-1]);
      end
      OpShl, OpShr: begin
        res_c = acc_q;
        c_c   = sc_q;
      end
      OpMul: begin
        res_c = acc_q;
        c_c   = |hi_q;
      end
      default: res_c = '0;
    endcase
  end

  // Partial-product step: multiplier sits in acc, high half accumulates in hi.
  assign mul_sum = {1'b0, hi_q} + ({1'b0, wa_q} & {(N + 1){acc_q[0]}});

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    wa_d     = wa_q;
    wb_d     = wb_q;
    wop_d    = wop_q;
    cin_d    = cin_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    sc_d     = sc_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (load_A)  a_d  = data_in;
        if (load_B)  b_d  = data_in;
        if (load_Op) op_d = data_in[2:0];
        if (start) begin
          state_d = StRun;
          wa_d    = a_q;
          wb_d    = b_q;
          wop_d   = op_q;
          cin_d   = flags_q[3];
          sc_d    = 1'b0;
          hi_d    = '0;
          unique case (op_e'(op_q))
            OpShl, OpShr: begin
              acc_d = a_q;
              cnt_d = CW'(b_q[KW-1:0]);
            end
            OpMul: begin
              acc_d = b_q;
              cnt_d = CW'(N);
            end
            default: begin
              acc_d = a_q;
              cnt_d = '0;
            end
          endcase
        end
      end
      StRun: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CW'(1);
          unique case (op_e'(wop_q))
            OpShl: begin
              sc_d  = acc_q[N-1];
              acc_d = {acc_q[N-2:0], 1'b0};
            end
            OpShr: begin
              sc_d  = acc_q[0];
              acc_d = {acc_q[N-1], acc_q[N-1:1]};
            end
            OpMul: {hi_d, acc_d} = {mul_sum, acc_q[N-1:1]};
            default: ;
          endcase
        end
      end
      StDone: begin
        state_d  = StIdle;
        result_d = res_c;
        flags_d  = {v_c, c_c, (res_c == '0), res_c[N-1], ~^res_c};
        done_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      wa_q     <= '0;
      wb_q     <= '0;
      wop_q    <= '0;
      cin_q    <= 1'b0;
      acc_q    <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
      sc_q     <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      wop_q    <= wop_d;
      cin_q    <= cin_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      sc_q     <= sc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = done_q;
  assign result = result_q;
  assign flags  = flags_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed plus randomized bench for alu_seq_unit, checked against an arithmetic reference model.
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        reset, load_A, load_B, load_Op, start;
  logic [15:0] data_in;
  logic        busy, done;
  logic [15:0] result;
  logic [4:0]  flags;

  int errors = 0;
  int checks = 0;

  // Model of the architectural registers and carry flag.
  logic [15:0] m_a, m_b;
  logic [2:0]  m_op;
  logic        m_c;

  alu_seq_unit #(.N(16)) dut (
    .clk     (clk),
    .reset   (reset),
    .load_A  (load_A),
    .load_B  (load_B),
    .load_Op (load_Op),
    .data_in (data_in),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .flags   (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_calc(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                          input logic cin, output logic [15:0] r, output logic [4:0] f,
                          output int lat);
    int k, s;
    logic c, v;
    logic [31:0] w;
    k = int'(b % 16);
    c = 1'b0;
    v = 1'b0;
    lat = 2;
    r = '0;
    case (op)
      3'd0: r = ~(a | b);
      3'd1: r = ~(a & b);
      3'd2, 3'd4: begin
        w = 32'(a) + 32'(b) + 32'((op == 3'd4) && cin);
        s = int'($signed(a)) + int'($signed(b)) + ((op == 3'd4) ? int'(cin) : 0);
        r = w[15:0];
        c = w[16];
        v = (s > 32767) || (s < -32768);
      end
      3'd3: begin
        r = a - b;
        c = (a < b);
        s = int'($signed(a)) - int'($signed(b));
        v = (s > 32767) || (s < -32768);
      end
      3'd5: begin
        w = 32'(a) << k;
        r = w[15:0];
        c = w[16];
        lat = 2 + k;
      end
      3'd6: begin
        r = 16'($signed(a) >>> k);
        c = (k == 0) ? 1'b0 : a[k-1];
        lat = 2 + k;
      end
      default: begin
        w = 32'(a) * 32'(b);
        r = w[15:0];
        c = |w[31:16];
        lat = 18;
      end
    endcase
    f = {v, c, (r == 16'h0), r[15], ~^r};
  endtask

  task automatic load_regs(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    data_in = a;
    load_A  = 1'b1;
    step();
    load_A  = 1'b0;
    data_in = b;
    load_B  = 1'b1;
    step();
    load_B  = 1'b0;
    data_in = {13'b0, op};
    load_Op = 1'b1;
    step();
    load_Op = 1'b0;
    m_a  = a;
    m_b  = b;
    m_op = op;
  endtask

  // Starts the operation held in the registers, waits for done and checks everything.
  task automatic exec(input string tag, input bit inject);
    logic [15:0] r, prev_res;
    logic [4:0]  f, prev_flags;
    int lat, n;
    bit held;
    ref_calc(m_a, m_b, m_op, m_c, r, f, lat);
    prev_res   = result;
    prev_flags = flags;
    held = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 200) begin
      if (inject && n == 3) begin
        load_A  = 1'b1;
        load_B  = 1'b1;
        load_Op = 1'b1;
        data_in = 16'($urandom);
        start   = 1'b1;
      end
      step();
      n++;
      load_A  = 1'b0;
      load_B  = 1'b0;
      load_Op = 1'b0;
      start   = 1'b0;
      if (!done && (result !== prev_res || flags !== prev_flags)) held = 1'b0;
    end
    check({tag, "_latency"}, 32'(n), 32'(lat));
    check({tag, "_result"}, 32'(result), 32'(r));
    check({tag, "_flags"}, 32'(flags), 32'(f));
    check({tag, "_held"}, 32'(held), 32'd1);
    m_c = f[3];
    step();
    check({tag, "_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, t1;
    bit saw_done;
    logic [15:0] ra, rb;
    logic [2:0] rop;

    reset = 1'b1;
    load_A = 1'b1;
    load_B = 1'b1;
    load_Op = 1'b1;
    start = 1'b1;
    data_in = 16'($urandom);
    step();
    data_in = 16'($urandom);
    step();
    reset = 1'b0;
    load_A = 1'b0;
    load_B = 1'b0;
    load_Op = 1'b0;
    start = 1'b0;
    m_a = '0;
    m_b = '0;
    m_op = '0;
    m_c = 1'b0;
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    step();
    check("rst_start_ignored", 32'(busy), 32'd0);
    // Registers cleared by reset: NOR of zeros.
    exec("rst_regs", 1'b0);

    load_regs(16'h7FFF, 16'h0001, 3'd2);
    exec("add_ovf", 1'b0);
    check("add_ovf_lit", 32'({result, flags}), 32'({16'h8000, 5'b10010}));

    load_regs(16'd5, 16'd5, 3'd3);
    exec("sub_zero", 1'b0);
    check("sub_zero_lit", 32'({result, flags}), 32'({16'h0000, 5'b00101}));
    load_regs(16'hFFFF, 16'h0001, 3'd2);
    exec("add_carry", 1'b0);
    check("add_carry_c", 32'(flags[3]), 32'd1);
    load_regs(16'h0000, 16'h0000, 3'd4);
    exec("addc", 1'b0);
    check("addc_lit", 32'(result), 32'h0001);

    load_regs(16'h8000, 16'd4, 3'd6);
    exec("shr", 1'b0);
    check("shr_lit", 32'({result, flags}), 32'({16'hF800, 5'b00010}));

    load_regs(16'h8001, 16'd1, 3'd5);
    exec("shl", 1'b0);
    check("shl_lit", 32'({result, flags[3]}), 32'({16'h0002, 1'b1}));

    load_regs(16'h0100, 16'h0101, 3'd7);
    exec("mul", 1'b1);
    check("mul_lit", 32'({result, flags}), 32'({16'h0100, 5'b01000}));
    // Mid-run loads must not have changed A/B/OpCode.
    exec("mul_again", 1'b0);

    // Start held high: next operation accepted only after the DONE cycle.
    load_regs(16'd3, 16'd4, 3'd2);
    start = 1'b1;
    n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
    t1 = n;
    step();
    n++;
    while (!done && n < 50) begin
      step();
      n++;
    end
    start = 1'b0;
    check("b2b_first", 32'(t1), 32'd3);
    check("b2b_gap", 32'(n - t1), 32'd3);
    check("b2b_result", 32'(result), 32'd7);
    m_c = 1'b0;
    step();
    check("b2b_idle", 32'(busy), 32'd0);

    // Abort a multiply with reset partway through RUN.
    load_regs(16'h1234, 16'h5678, 3'd7);
    start = 1'b1;
    step();
    start = 1'b0;
    saw_done = 1'b0;
    repeat (7) begin
      step();
      if (done) saw_done = 1'b1;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_a = '0;
    m_b = '0;
    m_op = '0;
    m_c = 1'b0;
    check("abort_no_done", 32'(saw_done | done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    load_regs(16'h0011, 16'h0022, 3'd2);
    exec("post_abort", 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 3'($urandom_range(0, 7));
      load_regs(ra, rb, rop);
      exec($sformatf("rand%0d_op%0d", i, rop), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
